// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit: funct3
// encodings, controller states and the access-size helper.
package mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } mem_state_t;

  // Signed and unsigned variants share a size; 111 maps to 8 but is rejected upstream.
  function automatic logic [3:0] access_bytes(input logic [2:0] func3);
    logic [3:0] n;
    case (func3)
      3'b000, 3'b100: n = 4'd1;
      3'b001, 3'b101: n = 4'd2;
      3'b010, 3'b110: n = 4'd4;
      default:        n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational store merge: replaces size_i bytes of the old doubleword,
// starting at lane offset_i, with the low bytes of the store data.
module byte_lane_merge
  import mem_pkg::*;
(
  input  logic [63:0] old_dw_i,
  input  logic [63:0] store_data_i,
  input  logic [2:0]  offset_i,
  input  logic [3:0]  size_i,
  output logic [63:0] merged_o
);

  logic [63:0] shifted;
  logic [7:0]  lane_en;

  assign shifted = store_data_i << {offset_i, 3'b000};

  always_comb begin
    lane_en  = '0;
    merged_o = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      lane_en[i] = (i >= 32'(offset_i)) && (i < 32'(offset_i) + 32'(size_i));
      merged_o[8*i +: 8] = lane_en[i] ? shifted[8*i +: 8] : old_dw_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle data-memory access controller: aligned doubleword loads with
// right-justified result, sd direct write, sb/sh/sw read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned ADDR_W      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              we,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [63:0]       mem_rdata,
  output logic [63:0]       load_raw,
  output logic [2:0]        func3_out,
  output logic              busy,
  output logic              done,
  output logic              misalign,
  output logic              bus_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYC - 1);

  mem_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        func3_q, func3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       sdata_q, sdata_d;
  logic [63:0]       merge_q, merge_d;
  logic [63:0]       raw_q, raw_d;
  logic [2:0]        f3o_q, f3o_d;
  logic [CW-1:0]     wait_q, wait_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;

  logic [3:0]  size;
  logic [2:0]  req_lo_mask;
  logic        req_bad_f3;
  logic [63:0] merged;

  assign size        = access_bytes(func3_q);
  assign req_lo_mask = 3'(access_bytes(func3) - 4'd1);
  assign req_bad_f3  = we ? func3[2] : (func3 == 3'b111);

  byte_lane_merge u_merge (
    .old_dw_i     (merge_q),
    .store_data_i (sdata_q),
    .offset_i     (addr_q[2:0]),
    .size_i       (size),
    .merged_o     (merged)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    func3_d = func3_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    merge_d = merge_q;
    raw_d   = raw_q;
    f3o_d   = f3o_q;
    wait_d  = wait_q;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          we_d    = we;
          func3_d = func3;
          addr_d  = addr;
          sdata_d = store_data;
          wait_d  = '0;
          if (req_bad_f3) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (|(addr[2:0] & req_lo_mask)) begin
            mis_d   = 1'b1;
            state_d = S_DONE;
          end else if (we && func3 == SD) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (mem_ready) begin
          wait_d = '0;
          if (we_q) begin
            merge_d = mem_rdata;
            state_d = S_WRITE;
          end else begin
            raw_d   = mem_rdata >> {addr_q[2:0], 3'b000};
            f3o_d   = func3_q;
            state_d = S_DONE;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          state_d = S_DONE;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      func3_q <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      merge_q <= '0;
      raw_q   <= '0;
      f3o_q   <= '0;
      wait_q  <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      merge_q <= merge_d;
      raw_q   <= raw_d;
      f3o_q   <= f3o_d;
      wait_q  <= wait_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = (state_q == S_READ) || (state_q == S_WRITE);
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem_wdata = mem_we ? merged : '0;
  assign load_raw  = raw_q;
  assign func3_out = f3o_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign misalign  = mis_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model predicts every cycle of
// each access; a randomized memory responder supplies wait states and data.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, start, we;
  logic [2:0]  func3;
  logic [63:0] addr, store_data;
  logic        mem_req, mem_we, mem_ready;
  logic [63:0] mem_addr, mem_wdata, mem_rdata, load_raw;
  logic [2:0]  func3_out;
  logic        busy, done, misalign, bus_err;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(TO), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset), .start(start), .we(we), .func3(func3),
    .addr(addr), .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .load_raw(load_raw), .func3_out(func3_out),
    .busy(busy), .done(done), .misalign(misalign), .bus_err(bus_err)
  );

  typedef struct packed {
    logic busy, done, mis, err, req, we;
    logic [63:0] addr, wdata, raw;
    logic [2:0] f3;
  } exp_t;

  // Driver/model/compare state (driver process only).
  exp_t        exp_q [int];
  logic [63:0] mdl [logic [63:0]];
  logic [63:0] m_raw = '0, idle_raw = '0;
  logic [2:0]  m_f3 = '0, idle_f3 = '0;
  int          cyc = 0, checks = 0, errors = 0, req_cycles = 0, last_done = 0;
  bit          chk_en = 0, last_mis = 0, last_err = 0;
  int          wait_rd = 0, wait_wr = 0;

  // Responder state (responder process only).
  logic [63:0] mem [logic [63:0]];
  int          rcnt = 0, rd_done = 0, wr_done = 0;
  bit          p_req = 0, p_we = 0, p_rdy = 0, rdy = 0;
  logic [63:0] last_addr = '0;

  function automatic logic [63:0] init_word(input int i);
    return (64'h9E3779B97F4A7C15 * 64'(i + 7)) ^ 64'hA5A5_0F0F_3C3C_6996;
  endfunction

  function automatic logic [63:0] merge_ref(input logic [63:0] old, d, input int off, n);
    logic [63:0] r;
    r = old;
    for (int k = 0; k < n; k++)
      if (off + k < 8) r[8*(off+k) +: 8] = d[8*k +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare_cycle();
    exp_t e;
    if (exp_q.exists(cyc)) begin
      e = exp_q[cyc];
      exp_q.delete(cyc);
    end else begin
      e = '0;
      e.raw = idle_raw;
      e.f3 = idle_f3;
    end
    chk("busy", busy, e.busy);
    chk("done", done, e.done);
    chk("misalign", misalign, e.mis);
    chk("bus_err", bus_err, e.err);
    chk("mem_req", mem_req, e.req);
    chk("mem_we", mem_we, e.we);
    chk("mem_wdata", mem_wdata, e.wdata);
    chk("load_raw", load_raw, e.raw);
    chk("func3_out", func3_out, e.f3);
    if (e.req) chk("mem_addr", mem_addr, e.addr);
    if (done) begin last_done = cyc; last_mis = misalign; last_err = bus_err; end
    if (mem_req) req_cycles++;
    if (e.done) begin idle_raw = e.raw; idle_f3 = e.f3; end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Per-cycle prediction of one accepted access started in cycle c0.
  task automatic plan(input bit w, input logic [2:0] f, input logic [63:0] a, d,
                      input int wr, ww, c0, output int dc);
    int n, off, c, ph;
    bit to;
    exp_t e, r;
    logic [63:0] al, old, wv;
    n = 1 << f[1:0];
    off = int'(a[2:0]);
    al = a & ~64'h7;
    c = c0 + 1;
    to = 0;
    old = mdl[al];
    wv = merge_ref(old, d, off, n);
    e = '0;
    e.busy = 1;
    e.raw = m_raw;
    e.f3 = m_f3;
    if ((!w && f == 3'b111) || (w && f[2])) e.err = 1;
    else if (off % n != 0) e.mis = 1;
    else begin
      if (!w || n != 8) begin
        ph = (wr >= TO) ? TO : wr + 1;
        for (int k = 0; k < ph; k++) begin
          r = e; r.req = 1; r.addr = al;
          exp_q[c] = r;
          c++;
        end
        to = (wr >= TO);
      end
      if (w && !to) begin
        ph = (ww >= TO) ? TO : ww + 1;
        for (int k = 0; k < ph; k++) begin
          r = e; r.req = 1; r.we = 1; r.addr = al; r.wdata = wv;
          exp_q[c] = r;
          c++;
        end
        to = (ww >= TO);
        if (!to) mdl[al] = wv;
      end
      if (!w && !to) begin
        m_raw = old >> (8 * off);
        m_f3 = f;
      end
      e.err = to;
    end
    e.done = 1;
    e.raw = m_raw;
    e.f3 = m_f3;
    exp_q[c] = e;
    dc = c;
  endtask

  task automatic issue(input bit w, input logic [2:0] f, input logic [63:0] a, d,
                       input int wr, ww, input bit done_start, output int c0);
    int dc;
    c0 = cyc;
    wait_rd = wr;
    wait_wr = ww;
    we = w; func3 = f; addr = a; store_data = d; start = 1;
    plan(w, f, a, d, wr, ww, c0, dc);
    do begin
      tick();
      start = ($urandom_range(0, 2) == 0);
      we = 1'($urandom);
      func3 = 3'($urandom);
      addr = {$urandom, $urandom};
      store_data = {$urandom, $urandom};
    end while (cyc < dc);
    if (done_start) begin
      start = 1; we = 0; func3 = 3'b011; addr = 64'h4000;
    end
    tick();
    start = 0;
  endtask

  // Memory responder: counts wait states per request phase, injects stray mem_ready while idle.
  initial begin
    mem_ready = 0;
    mem_rdata = '0;
    for (int s = 0; s < 8; s++) mem[64'h4000 + 64'(8 * s)] = init_word(s);
    mem[64'h1000] = 64'h8877665544332211;
    mem[64'h2000] = 64'h1111111111111111;
    mem[64'h3000] = init_word(99);
    forever begin
      @(posedge clk);
      #2;
      if (mem_req && (!p_req || p_we != mem_we || p_rdy)) rcnt = 0;
      else if (mem_req) rcnt++;
      rdy = mem_req && (rcnt == (mem_we ? wait_wr : wait_rd));
      mem_rdata = {$urandom, $urandom};
      if (rdy) begin
        last_addr = mem_addr;
        if (mem_we) begin mem[mem_addr] = mem_wdata; wr_done++; end
        else begin mem_rdata = mem[mem_addr]; rd_done++; end
        mem_ready = 1;
      end else begin
        mem_ready = !mem_req && ($urandom_range(0, 3) == 0);
      end
      p_req = mem_req; p_we = mem_we; p_rdy = rdy;
    end
  end

  initial begin
    int c0, rb, wb, rq, n, off, slot, wr, ww;
    bit w;
    logic [2:0] f;
    for (int s = 0; s < 8; s++) mdl[64'h4000 + 64'(8 * s)] = init_word(s);
    mdl[64'h1000] = 64'h8877665544332211;
    mdl[64'h2000] = 64'h1111111111111111;
    mdl[64'h3000] = init_word(99);
    reset = 1; start = 0; we = 0; func3 = '0; addr = '0; store_data = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_raw", load_raw, 0);
    reset = 0;
    chk_en = 1;

    // ld with three wait states
    issue(0, 3'b011, 64'h1000, 0, 3, 0, 0, c0);
    chk("t1_addr", last_addr, 64'h1000);
    chk("t1_raw", load_raw, 64'h8877665544332211);
    chk("t1_latency", 64'(last_done - c0), 5);
    // lb at byte 5
    issue(0, 3'b000, 64'h1005, 0, 0, 0, 0, c0);
    chk("t2_raw", load_raw, 64'h0000000000887766);
    chk("t2_func3", func3_out, 3'b000);
    chk("t2_latency", 64'(last_done - c0), 2);
    // sh read-modify-write
    rb = rd_done; wb = wr_done;
    issue(1, 3'b001, 64'h2002, 64'hABCD, 0, 0, 0, c0);
    chk("t3_mem", mem[64'h2000], 64'h11111111ABCD1111);
    chk("t3_reads", 64'(rd_done - rb), 1);
    chk("t3_writes", 64'(wr_done - wb), 1);
    chk("t3_latency", 64'(last_done - c0), 3);
    // sd direct write
    rb = rd_done;
    issue(1, 3'b011, 64'h3000, 64'h0123456789ABCDEF, 0, 0, 0, c0);
    chk("sd_mem", mem[64'h3000], 64'h0123456789ABCDEF);
    chk("sd_reads", 64'(rd_done - rb), 0);
    chk("sd_latency", 64'(last_done - c0), 2);
    // misaligned lw
    rq = req_cycles;
    issue(0, 3'b010, 64'h3006, 0, 0, 0, 0, c0);
    chk("t4_mis", last_mis, 1);
    chk("t4_latency", 64'(last_done - c0), 1);
    chk("t4_noreq", 64'(req_cycles - rq), 0);
    // timeout with mem_ready never arriving
    issue(0, 3'b011, 64'h1000, 0, 50, 0, 0, c0);
    chk("t5_err", last_err, 1);
    chk("t5_latency", 64'(last_done - c0), 1 + TO);
    chk("t5_raw_held", load_raw, 64'h0000000000887766);
    chk("t5_idle", busy, 0);

    // reset during WRITE of an sb
    chk_en = 0;
    wait_rd = 0; wait_wr = 3;
    we = 1; func3 = 3'b000; addr = 64'h400B; store_data = 64'hEE; start = 1;
    tick();
    start = 0;
    tick();
    chk("t6_in_write", mem_we, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("t6_req", mem_req, 0);
    chk("t6_we", mem_we, 0);
    chk("t6_addr", mem_addr, 0);
    chk("t6_wdata", mem_wdata, 0);
    chk("t6_raw", load_raw, 0);
    chk("t6_f3", func3_out, 0);
    chk("t6_busy", busy, 0);
    chk("t6_flags", {done, misalign, bus_err}, 0);
    m_raw = '0; m_f3 = '0; idle_raw = '0; idle_f3 = '0;
    chk_en = 1;
    rq = req_cycles;
    issue(0, 3'b001, 64'h4001, 0, 0, 0, 1, c0);
    repeat (3) tick();
    chk("t6_ignored_start", 64'(req_cycles - rq), 0);
    chk("t6_nowrite", mem[64'h4008], init_word(1));

    for (int i = 0; i < 200; i++) begin
      w = 1'($urandom);
      f = 3'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (w) f[2] = 1'b0;
        else if (f == 3'b111) f = 3'b011;
      end
      n = 1 << f[1:0];
      off = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) off = (off / n) * n;
      slot = $urandom_range(0, 7);
      wr = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 3);
      ww = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 3);
      issue(w, f, 64'h4000 + 64'(8 * slot + off), {$urandom, $urandom}, wr, ww,
            1'($urandom), c0);
      repeat ($urandom_range(0, 2)) tick();
    end

    for (int s = 0; s < 8; s++)
      chk("final_mem", mem[64'h4000 + 64'(8 * s)], mdl[64'h4000 + 64'(8 * s)]);
    chk("final_mem_2000", mem[64'h2000], mdl[64'h2000]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
